sorted_result_tx: RTL and testbench
===================================

// Module: sorted_result_tx
// PURPOSE
//  Serial reporter for the sort machine's results. It snapshots the NUM_ELEMS sorted registers on a
//  start pulse and transmits them over a UART line (8N1, LSB first) on a GPIO pin as ASCII text.
//  Format: uppercase hex digits, one space between elements, "\r\n" at the end. Element 0 is sent first.
//  It sits beside the hex-display path in the top level and consumes the same register values.
// PARAMETERS
//  CLK_HZ     50_000_000  input clock frequency
//  BAUD       115_200     line rate; DIV = CLK_HZ/BAUD, truncated (434 at defaults)
//  NUM_ELEMS  4           number of sorted elements, 2..16
//  ELEM_W     4           element width; multiple of 4, range 4..16; DIGITS = ELEM_W/4
// PORTS
//  clk    in   1                  system clock
//  rst    in   1                  asynchronous, active-high reset
//  start  in   1                  single-cycle request to snapshot elems and transmit
//  elems  in   NUM_ELEMS*ELEM_W   element i at [i*ELEM_W +: ELEM_W]
//  busy   out  1                  high from the cycle after start is accepted until done
//  done   out  1                  one-cycle pulse when the final stop bit completes
//  txd    out  1                  UART serial output; idle level is 1
// BEHAVIOUR
//  Reset: txd=1, busy=0, done=0, all FSMs in IDLE, counters 0. Reset is asserted asynchronously.
//   If reset lands mid-frame, txd goes to 1 immediately and the message is abandoned.
//  Message FSM states:
//   IDLE -> LOAD on start; elems are captured into a snapshot register in the same edge; busy=1 next cycle.
//   LOAD -> SEND: select the next byte (digit, space, CR or LF) and pulse byte_valid to the serializer.
//   SEND -> WAIT: hold until byte_done.
//   WAIT -> LOAD while bytes remain; otherwise go to DONE.
//   DONE -> IDLE: done=1 for exactly one cycle; busy drops in the same cycle.
//  Byte order: for each element i = 0..NUM_ELEMS-1, send DIGITS digits MSB-nibble first.
//   A space (0x20) follows every element except the last. Then CR (0x0D), then LF (0x0A).
//   Byte count = NUM_ELEMS*DIGITS + NUM_ELEMS-1 + 2 (9 bytes at defaults).
//  Nibble to ASCII: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46.
//  start while busy: ignored; no queueing, and the snapshot is unchanged. start coincident with rst: rst wins.
//  elems may change freely after capture; the transmitted data is the snapshot.
//  Serializer: START bit (0), 8 DATA bits LSB first, STOP bit (1). Each bit lasts exactly DIV cycles.
//   The baud counter restarts at 0 at each bit boundary and counts 0..DIV-1 with no drift.
//  Latency: start sampled at edge N -> txd falls at edge N+2. Byte frames are back-to-back,
//   with at most 2 idle cycles between a stop bit and the next start bit.
//  done occurs 1 cycle after the last stop bit ends; txd is 1 from then on.
// CONFIGURATION
//  SORT_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) is inserted between
//   DATA and STOP. Frame = 11 bits.
//  Without it: 8N1, frame = 10 bits, and no parity state or logic is present.
// STRUCTURE
//  sort_pkg: msg_state_t and ser_state_t enums; ASCII_SP, ASCII_CR, ASCII_LF constants;
//   function hex_to_ascii(logic [3:0]) -> logic [7:0].
//  Sub-module uart_tx_byte (params CLK_HZ, BAUD):
//   ports clk, rst, byte_valid, byte_data[7:0], byte_ready, byte_done, txd; owns the baud counter and bit counter.
//  sorted_result_tx: snapshot register, byte/digit/element counters, message FSM, one uart_tx_byte instance.
// TESTING (defaults, DIV=434, bit sampled at its midpoint)
//  1. rst pulse mid-run -> txd=1, busy=0, done=0 immediately; no spurious start bit afterwards.
//  2. elems={4'hC,4'h9,4'h3,4'h1} (element0=1), start -> bytes 31 20 33 20 39 20 43 0D 0A;
//     done once, after 9*10*434 + <=20 cycles.
//  3. Second start 1000 cycles into a message, with elems changed -> ignored; the original 9 bytes are sent unchanged.
//  4. elems=16'hFA05 -> "5 0 A F\r\n", covering the 0-9 and A-F ASCII boundaries.
//  5. rst asserted during the DATA bits of byte 3 -> txd=1 at once. A new start then sends the full message from byte 0.
//  6. With SORT_TX_PARITY_EN: elems={0,0,0,7} -> byte 0x37 has parity bit 1; frame length 11*434 cycles.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and ASCII helpers for the sorted-result UART reporter.
// SORT_TX_PARITY_EN adds the even-parity serializer state.
package sort_pkg;

  typedef enum logic [2:0] {
    M_IDLE,
    M_LOAD,
    M_SEND,
    M_WAIT,
    M_DONE
  } msg_state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SORT_TX_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } ser_state_t;

  typedef enum logic [1:0] {
    K_DIG,
    K_SP,
    K_CR,
    K_LF
  } kind_t;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [7:0] hex_to_ascii(
    input logic [3:0] n
  );
    return (n < 4'd10) ? (8'h30 + {4'h0, n})
                       : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/sorted_result_tx_if.sv
// Handshake/data bundle between the sort machine top
// level and the result reporter.
interface sorted_result_tx_if #(
  parameter int NUM_ELEMS = 4,
  parameter int ELEM_W    = 4
);
  logic                          start;
  logic [NUM_ELEMS*ELEM_W-1:0]   elems;
  logic                          busy;
  logic                          done;
  logic                          txd;

  modport master (
    output start, elems,
    input  busy, done, txd
  );

  modport slave (
    input  start, elems,
    output busy, done, txd
  );
endinterface

// File: rtl/sorted_result_tx_uart_tx_byte.sv
// One-byte UART framer (START, 8 data LSB first, STOP).
// SORT_TX_PARITY_EN inserts an even-parity bit before STOP.
module uart_tx_byte
  import sort_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       byte_done,
  output logic       txd
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  ser_state_t    state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_i;
  logic [7:0]    data_q;
  logic          txd_d;
  logic          bit_end;

  assign bit_end = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (byte_valid) nxt = S_START;
      S_START: if (bit_end) nxt = S_DATA;
`ifdef SORT_TX_PARITY_EN
      S_DATA:  if (bit_end && bit_i == 3'd7) nxt = S_PAR;
      S_PAR:   if (bit_end) nxt = S_STOP;
`else
      S_DATA:  if (bit_end && bit_i == 3'd7) nxt = S_STOP;
`endif
      S_STOP:  if (bit_end) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    txd_d      = 1'b1;
    byte_ready = 1'b0;
    byte_done  = 1'b0;
    unique case (state)
      S_IDLE:  byte_ready = 1'b1;
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = data_q[bit_i];
`ifdef SORT_TX_PARITY_EN
      S_PAR:   txd_d = ^data_q;
`endif
      S_STOP:  byte_done = bit_end;
      default: txd_d = 1'b1;
    endcase
  end

  // txd is registered, so every bit is shifted one cycle after its state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      bit_i  <= '0;
      data_q <= '0;
      txd    <= 1'b1;
    end else begin
      txd <= txd_d;
      if (state == S_IDLE) begin
        cnt   <= '0;
        bit_i <= '0;
        if (byte_valid) data_q <= byte_data;
      end else if (bit_end) begin
        cnt <= '0;
        if (state == S_DATA) bit_i <= bit_i + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sorted_result_tx.sv
// Snapshots the sorted registers and reports them as hex
// ASCII over UART; SORT_TX_PARITY_EN selects an 8E1 frame.
module sorted_result_tx
  import sort_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int NUM_ELEMS = 4,
  parameter int ELEM_W    = 4
) (
  input logic               clk,
  input logic               rst,
  sorted_result_tx_if.slave bus
);

  localparam int DIGITS = ELEM_W / 4;
  localparam int W      = NUM_ELEMS * ELEM_W;

  msg_state_t state, nxt;
  logic [W-1:0] snap;
  logic [3:0]   elem_i;
  logic [1:0]   dig_i;
  kind_t        kind;
  logic [3:0]   nib;
  logic [7:0]   byte_data;
  logic         byte_valid;
  logic         byte_ready;
  logic         byte_done;
  logic         last_elem;
  logic         last_dig;

  assign last_elem = (elem_i == 4'(NUM_ELEMS - 1));
  assign last_dig  = (dig_i == 2'(DIGITS - 1));

  // element i, digit d (MSB first) sits at nibble i*DIGITS + DIGITS-1-d
  assign nib = 4'(snap >> (4 * (int'(elem_i) * DIGITS
                                + DIGITS - 1 - int'(dig_i))));

  always_comb begin
    unique case (kind)
      K_DIG: byte_data = hex_to_ascii(nib);
      K_SP:  byte_data = ASCII_SP;
      K_CR:  byte_data = ASCII_CR;
      K_LF:  byte_data = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= M_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      M_IDLE:  if (bus.start) nxt = M_LOAD;
      M_LOAD:  if (byte_ready) nxt = M_SEND;
      M_SEND:  if (byte_done) nxt = M_WAIT;
      M_WAIT:  nxt = (kind == K_LF) ? M_DONE : M_LOAD;
      M_DONE:  nxt = M_IDLE;
      default: nxt = M_IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state == M_LOAD) || (state == M_SEND)
              || (state == M_WAIT);
    bus.done   = (state == M_DONE);
    byte_valid = (state == M_LOAD) && byte_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap   <= '0;
      elem_i <= '0;
      dig_i  <= '0;
      kind   <= K_DIG;
    end else if (state == M_IDLE && bus.start) begin
      snap   <= bus.elems;
      elem_i <= '0;
      dig_i  <= '0;
      kind   <= K_DIG;
    end else if (state == M_WAIT) begin
      unique case (kind)
        K_DIG: begin
          if (last_dig) begin
            dig_i <= '0;
            kind  <= last_elem ? K_CR : K_SP;
          end else begin
            dig_i <= dig_i + 2'd1;
          end
        end
        K_SP: begin
          elem_i <= elem_i + 4'd1;
          kind   <= K_DIG;
        end
        K_CR: kind <= K_LF;
        K_LF: kind <= K_LF;
      endcase
    end
  end

  uart_tx_byte #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .byte_done (byte_done),
    .txd       (bus.txd)
  );

endmodule

// File: tb/tb_sorted_result_tx.sv
// Directed bench for sorted_result_tx: UART frame decoder
// against a queue of expected bytes.
module tb_sorted_result_tx;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 3_000_000;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef SORT_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int MSG_CYC = 9 * FB * DIV;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sorted_result_tx_if #(.NUM_ELEMS(4), .ELEM_W(4)) bus ();

  sorted_result_tx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD),
    .NUM_ELEMS(4), .ELEM_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int frames = 0;
  int dones  = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int mcnt = 0;
  bit mact = 0;
  logic [7:0] mbyte;
  logic [7:0] eb;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] asc(input logic [3:0] n);
    if (n <= 4'd9) return 8'd48 + 8'(n);
    return 8'd65 + 8'(n) - 8'd10;
  endfunction

  task automatic push_msg(input logic [15:0] e);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(asc(e[i*4 +: 4]));
      if (i < 3) exp_q.push_back(8'h20);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // frame decoder: samples each bit at its midpoint
  always @(negedge clk) begin
    if (rst) begin
      mact = 0;
    end else begin
      if (bus.done === 1'b1) begin
        dones++;
        done_cyc = cyc;
      end
      if (!mact) begin
        if (bus.txd === 1'b0) begin
          mact = 1;
          mcnt = 0;
        end
      end else begin
        mcnt++;
        if (mcnt == DIV / 2)
          chk("start_bit", 32'(bus.txd), 32'd0);
        if (mcnt >= DIV / 2 + DIV && mcnt < DIV / 2 + 9 * DIV
            && ((mcnt - DIV / 2) % DIV) == 0)
          mbyte[(mcnt - DIV / 2) / DIV - 1] = bus.txd;
`ifdef SORT_TX_PARITY_EN
        if (mcnt == DIV / 2 + 9 * DIV)
          chk("parity_bit", 32'(bus.txd), 32'(^mbyte));
`endif
        if (mcnt == DIV / 2 + (FB - 1) * DIV) begin
          chk("stop_bit", 32'(bus.txd), 32'd1);
          chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            eb = exp_q.pop_front();
            chk("byte_data", 32'(mbyte), 32'(eb));
          end
          frames++;
          mact = 0;
        end
      end
    end
  end

  task automatic send_start(input logic [15:0] e, input bit push);
    @(negedge clk);
    bus.elems = e;
    bus.start = 1'b1;
    start_cyc = cyc + 1;
    if (push) push_msg(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = dones;
    n = 0;
    while (dones == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(dones != d0), 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int f0;
    int lat;
    int n;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.elems = '0;
    wait_cycles(3);
    chk("rst_txd", 32'(bus.txd), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_cycles(3);

    // basic message, start-to-txd latency and done timing
    d0 = dones;
    send_start(16'hC931, 1);
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("txd_n1", 32'(bus.txd), 32'd1);
    @(negedge clk);
    chk("txd_n1b", 32'(bus.txd), 32'd1);
    @(negedge clk);
    chk("txd_n2", 32'(bus.txd), 32'd0);
    wait_done(MSG_CYC + 200);
    lat = done_cyc - start_cyc;
    chk("done_latency",
        32'(lat >= MSG_CYC && lat <= MSG_CYC + 20), 32'd1);
    chk("queue_drained_1", 32'(exp_q.size()), 32'd0);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    wait_cycles(5);
    chk("done_once_1", 32'(dones - d0), 32'd1);
    chk("txd_idle_1", 32'(bus.txd), 32'd1);

    // start while busy is ignored and the snapshot is kept
    d0 = dones;
    f0 = frames;
    send_start(16'h5A7E, 1);
    wait_cycles(1000);
    send_start(16'h1234, 0);
    bus.elems = 16'hFFFF;
    wait_done(MSG_CYC + 200);
    wait_cycles(3 * FB * DIV);
    chk("frames_busy_start", 32'(frames - f0), 32'd9);
    chk("done_once_2", 32'(dones - d0), 32'd1);
    chk("queue_drained_2", 32'(exp_q.size()), 32'd0);

    // digit/letter ASCII boundaries
    send_start(16'hFA05, 1);
    wait_done(MSG_CYC + 200);
    wait_cycles(3);
    chk("queue_drained_3", 32'(exp_q.size()), 32'd0);

    // reset during data bits of byte 3
    f0 = frames;
    send_start(16'h8B62, 1);
    n = 0;
    while (frames < f0 + 3 && n < MSG_CYC) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus.txd !== 1'b0 && n < 4 * DIV) begin
      @(negedge clk);
      n++;
    end
    chk("byte3_started", 32'(bus.txd), 32'd0);
    wait_cycles(3 * DIV);
    #2 rst = 1'b1;
    #1;
    chk("midrst_txd", 32'(bus.txd), 32'd1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    exp_q.delete();
    wait_cycles(2);
    @(posedge clk);
    #1 rst = 1'b0;
    f0 = frames;
    d0 = dones;
    wait_cycles(4 * FB * DIV);
    chk("no_spurious_frame", 32'(frames - f0), 32'd0);
    chk("no_spurious_done", 32'(dones - d0), 32'd0);
    chk("txd_idle_rst", 32'(bus.txd), 32'd1);
    send_start(16'h8B62, 1);
    wait_done(MSG_CYC + 200);
    wait_cycles(3);
    chk("restart_frames", 32'(frames - f0), 32'd9);
    chk("queue_drained_4", 32'(exp_q.size()), 32'd0);

`ifdef SORT_TX_PARITY_EN
    send_start(16'h0007, 1);
    wait_done(MSG_CYC + 200);
    lat = done_cyc - start_cyc;
    chk("parity_latency",
        32'(lat >= 99 * DIV && lat <= 99 * DIV + 20), 32'd1);
    wait_cycles(3);
    chk("queue_drained_5", 32'(exp_q.size()), 32'd0);
`endif

    wait_cycles(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
